// File: rtl/gpio_pad_pkg.sv
// Shared constants for the GPIO pad controller: pad enable polarity and sync depth floor.
package gpio_pad_pkg;

    localparam logic PAD_DRIVE       = 1'b0;
    localparam logic PAD_RELEASE     = 1'b1;
    localparam int   MIN_SYNC_STAGES = 2;

    // Maps a core-side "drive this pad" flag onto the pad's active-low c2p_en.
    function automatic logic pad_en(input logic drive);
        return drive ? PAD_DRIVE : PAD_RELEASE;
    endfunction

endpackage

// File: rtl/gpio_pad_ctrl_debounce.sv
// Per-pad input path: synchroniser, debounce counter, stable level and edge strobes.
module gpio_pad_debounce
    import gpio_pad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_p2c,
    input  logic [DEBOUNCE_W-1:0] i_limit,
    input  logic                  i_rise_en,
    input  logic                  i_fall_en,
    output logic                  o_stable,
    output logic                  o_rise,
    output logic                  o_fall
);

    localparam int STAGES = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;

    logic [STAGES-1:0]     r_sync;
    logic [DEBOUNCE_W-1:0] r_cnt;
    logic                  r_stable;
    logic                  w_sync;
    logic [DEBOUNCE_W:0]   w_cnt_inc;
    logic                  w_accept;

    assign w_sync    = r_sync[STAGES-1];
    assign w_cnt_inc = {1'b0, r_cnt} + {{DEBOUNCE_W{1'b0}}, 1'b1};
    // Using >= lets a lowered limit take effect on the very next cycle.
    assign w_accept  = (w_sync != r_stable) &&
                       ((i_limit == '0) || (w_cnt_inc >= {1'b0, i_limit}));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_p2c};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else if (w_sync == r_stable) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_stable <= w_sync;
            r_cnt    <= '0;
        end else begin
            r_cnt <= w_cnt_inc[DEBOUNCE_W-1:0];
        end
    end

    assign o_stable = r_stable;
    assign o_rise   = w_accept &  w_sync & i_rise_en;
    assign o_fall   = w_accept & ~w_sync & i_fall_en;

endmodule

// File: rtl/gpio_pad_ctrl.sv
// Core-side controller for a bank of bidirectional pads: output drive, debounced input, edge IRQs.
module gpio_pad_ctrl
    import gpio_pad_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE_W  = 8
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [WIDTH-1:0]      out_value,
    input  logic [WIDTH-1:0]      out_enable,
    input  logic [WIDTH-1:0]      open_drain,
    output logic [WIDTH-1:0]      c2p,
    output logic [WIDTH-1:0]      c2p_en,
    input  logic [WIDTH-1:0]      p2c,
    input  logic [DEBOUNCE_W-1:0] debounce_limit,
    output logic [WIDTH-1:0]      in_value,
    input  logic [WIDTH-1:0]      irq_rise_en,
    input  logic [WIDTH-1:0]      irq_fall_en,
    input  logic [WIDTH-1:0]      irq_clear,
    output logic [WIDTH-1:0]      irq_pending,
    output logic                  irq
);

    logic [WIDTH-1:0] r_c2p;
    logic [WIDTH-1:0] r_c2p_en;
    logic [WIDTH-1:0] r_pending;
    logic             r_irq;
    logic [WIDTH-1:0] w_drive;
    logic [WIDTH-1:0] w_c2p_en_next;
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;

    // Open-drain pads only ever pull low; a 1 is expressed by releasing the pad.
    assign w_drive = out_enable & ~(open_drain & out_value);

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_pad
            assign w_c2p_en_next[gi] = pad_en(w_drive[gi]);

            gpio_pad_debounce #(
                .SYNC_STAGES (SYNC_STAGES),
                .DEBOUNCE_W  (DEBOUNCE_W)
            ) u_debounce (
                .clk       (clk),
                .resetn    (resetn),
                .i_p2c     (p2c[gi]),
                .i_limit   (debounce_limit),
                .i_rise_en (irq_rise_en[gi]),
                .i_fall_en (irq_fall_en[gi]),
                .o_stable  (w_stable[gi]),
                .o_rise    (w_rise[gi]),
                .o_fall    (w_fall[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_c2p    <= '0;
            r_c2p_en <= {WIDTH{PAD_RELEASE}};
        end else begin
            r_c2p    <= out_value & ~open_drain;
            r_c2p_en <= w_c2p_en_next;
        end
    end

    // A new edge outranks a simultaneous clear so no event is lost.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_pending <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_pending <= (r_pending & ~irq_clear) | w_rise | w_fall;
            r_irq     <= |r_pending;
        end
    end

    assign c2p         = r_c2p;
    assign c2p_en      = r_c2p_en;
    assign in_value    = w_stable;
    assign irq_pending = r_pending;
    assign irq         = r_irq;

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Randomised and directed bench for gpio_pad_ctrl against a cycle-level behavioural model.
module tb_gpio_pad_ctrl;

    localparam int WIDTH = 8;
    localparam int SYNC  = 2;
    localparam int DW    = 8;

    logic             clk = 1'b0;
    logic             resetn;
    logic [WIDTH-1:0] out_value, out_enable, open_drain;
    logic [WIDTH-1:0] c2p, c2p_en, p2c, in_value;
    logic [DW-1:0]    debounce_limit;
    logic [WIDTH-1:0] irq_rise_en, irq_fall_en, irq_clear, irq_pending;
    logic             irq;

    gpio_pad_ctrl #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC), .DEBOUNCE_W(DW)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .out_value      (out_value),
        .out_enable     (out_enable),
        .open_drain     (open_drain),
        .c2p            (c2p),
        .c2p_en         (c2p_en),
        .p2c            (p2c),
        .debounce_limit (debounce_limit),
        .in_value       (in_value),
        .irq_rise_en    (irq_rise_en),
        .irq_fall_en    (irq_fall_en),
        .irq_clear      (irq_clear),
        .irq_pending    (irq_pending),
        .irq            (irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: pad level seen SYNC cycles late; accepted after a run of
    // max(limit,1) consecutive differing samples.
    logic [WIDTH-1:0] m_hist [SYNC];
    logic [WIDTH-1:0] m_stable, m_pend, m_c2p, m_en;
    logic             m_irq;
    int               m_run [WIDTH];

    task automatic model_reset();
        for (int k = 0; k < SYNC; k++) m_hist[k] = '0;
        for (int i = 0; i < WIDTH; i++) m_run[i] = 0;
        m_stable = '0;
        m_pend   = '0;
        m_c2p    = '0;
        m_en     = '1;
        m_irq    = 1'b0;
    endtask

    task automatic step(input string tag);
        logic [WIDTH-1:0] sync, n_stable, rise, fall;
        int need;
        sync = m_hist[SYNC-1];
        for (int k = SYNC-1; k > 0; k--) m_hist[k] = m_hist[k-1];
        m_hist[0] = p2c;
        need = (debounce_limit == 0) ? 1 : int'(debounce_limit);
        n_stable = m_stable;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] != m_stable[i]) begin
                m_run[i]++;
                if (m_run[i] >= need) begin
                    n_stable[i] = sync[i];
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        rise     = n_stable & ~m_stable & irq_rise_en;
        fall     = ~n_stable & m_stable & irq_fall_en;
        m_irq    = (m_pend != 0);
        m_pend   = (m_pend & ~irq_clear) | rise | fall;
        m_stable = n_stable;
        m_c2p    = out_value & ~open_drain;
        m_en     = ~(out_enable & ~(open_drain & out_value));
        @(posedge clk);
        #1;
        check({tag, "_c2p"},     32'(c2p),         32'(m_c2p));
        check({tag, "_c2p_en"},  32'(c2p_en),      32'(m_en));
        check({tag, "_in"},      32'(in_value),    32'(m_stable));
        check({tag, "_pending"}, 32'(irq_pending), 32'(m_pend));
        check({tag, "_irq"},     32'(irq),         32'(m_irq));
    endtask

    initial begin
        resetn = 1'b0;
        out_value = '0; out_enable = '0; open_drain = '0; p2c = '0;
        debounce_limit = '0; irq_rise_en = '0; irq_fall_en = '0; irq_clear = '0;
        model_reset();
        #12;
        resetn = 1'b1;
        #1;
        check("rst_c2p", 32'(c2p), 32'h00);
        check("rst_c2p_en", 32'(c2p_en), 32'hFF);
        check("rst_in", 32'(in_value), 32'h00);
        check("rst_irq", 32'(irq), 32'h0);

        out_enable = 8'h0F; out_value = 8'h05;
        step("pp");
        check("pp_c2p_k", 32'(c2p), 32'h05);
        check("pp_en_k", 32'(c2p_en), 32'hF0);

        open_drain = 8'h03; out_enable = 8'h03; out_value = 8'h01;
        step("od");
        check("od_c2p_k", 32'(c2p[1:0]), 32'h0);
        check("od_en_k", 32'(c2p_en[1:0]), 32'h1);

        debounce_limit = 8'd4; irq_rise_en = 8'h01; p2c = 8'h01;
        repeat (5) step("db4");
        check("db4_early", 32'(in_value[0]), 32'h0);
        step("db4");
        check("db4_accept", 32'(in_value[0]), 32'h1);
        check("db4_pend", 32'(irq_pending), 32'h01);
        step("db4");
        check("db4_irq", 32'(irq), 32'h1);

        irq_clear = 8'h01;
        step("clr");
        irq_clear = '0;
        check("clr_pend", 32'(irq_pending), 32'h00);

        irq_rise_en = 8'hFF; p2c = 8'h03;
        repeat (3) step("glitch");
        p2c = 8'h01;
        repeat (8) step("glitch");
        check("glitch_in", 32'(in_value[1]), 32'h0);
        check("glitch_irq", 32'(irq), 32'h0);

        debounce_limit = '0; p2c = 8'h05;
        repeat (2) step("byp");
        check("byp_early", 32'(in_value[2]), 32'h0);
        step("byp");
        check("byp_follow", 32'(in_value[2]), 32'h1);

        irq_clear = 8'hFF;
        step("clr_all");
        irq_clear = '0;
        p2c = 8'h00;
        repeat (4) step("fall_dis");
        check("fall_dis_pend", 32'(irq_pending), 32'h00);

        p2c = 8'h01;
        repeat (2) step("setclr");
        irq_clear = 8'h01;
        step("setclr");
        irq_clear = '0;
        check("setclr_pend", 32'(irq_pending[0]), 32'h1);

        open_drain = '0; out_enable = 8'hFF; out_value = 8'hAA;
        step("drv");
        check("drv_en", 32'(c2p_en), 32'h00);
        #3;
        resetn = 1'b0;
        #1;
        model_reset();
        check("async_en", 32'(c2p_en), 32'hFF);
        check("async_c2p", 32'(c2p), 32'h00);
        check("async_in", 32'(in_value), 32'h00);
        check("async_pend", 32'(irq_pending), 32'h00);
        check("async_irq", 32'(irq), 32'h0);
        #10;
        resetn = 1'b1;

        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 39) == 0) debounce_limit = DW'($urandom_range(0, 6));
            if ((n % 16) == 0) begin
                irq_rise_en = WIDTH'($urandom);
                irq_fall_en = WIDTH'($urandom);
            end
            p2c        = p2c ^ WIDTH'($urandom & $urandom & $urandom);
            out_value  = WIDTH'($urandom);
            out_enable = WIDTH'($urandom);
            open_drain = WIDTH'($urandom);
            irq_clear  = WIDTH'($urandom & $urandom & $urandom);
            step("rnd");
        end
        irq_clear = '0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
